// File: rtl/pet_controller.sv
// pet_controller: top-level sequencing FSM of the virtual-pet game (sprite requests + care pulses).
// Define PET_CTRL_KEY_SYNC_EN to pass start_key/care_key through a two-flop synchronizer.
module pet_controller #(
    parameter logic [5:0] ANIM_FRAMES = 6'd30
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start_key,
    input  logic [4:0] care_key,
    input  logic       hungry,
    input  logic       bored,
    input  logic       dirty,
    input  logic       sick,
    input  logic       dying,
    input  logic       deceased,
    input  logic       asleep,
    input  logic       frame_tick,
    input  logic       draw_done,
    output logic       draw_bg,
    output logic       draw_start,
    output logic       draw_end,
    output logic       draw_pet,
    output logic       draw_zs,
    output logic       draw_food,
    output logic       draw_ball,
    output logic       draw_broom,
    output logic       draw_pills,
    output logic       draw_firstAid,
    output logic       draw_hunger,
    output logic       draw_bored,
    output logic       draw_dirty,
    output logic       draw_sick,
    output logic       draw_dying,
    output logic       foodGiven,
    output logic       ballGiven,
    output logic       broomGiven,
    output logic       pillsGiven,
    output logic       firstAidGiven
);

    typedef enum logic [3:0] {
        ST_RST,
        ST_START,
        ST_WAIT_START,
        ST_BG,
        ST_PET,
        ST_STATUS,
        ST_ZS,
        ST_OBJ,
        ST_IDLE,
        ST_GIVE,
        ST_END,
        ST_DEAD
    } state_t;

    localparam logic [2:0] IT_NONE  = 3'd0;
    localparam logic [2:0] IT_FOOD  = 3'd1;
    localparam logic [2:0] IT_BALL  = 3'd2;
    localparam logic [2:0] IT_BROOM = 3'd3;
    localparam logic [2:0] IT_PILLS = 3'd4;
    localparam logic [2:0] IT_AID   = 3'd5;

    localparam int D_BG     = 0;
    localparam int D_START  = 1;
    localparam int D_END    = 2;
    localparam int D_PET    = 3;
    localparam int D_ZS     = 4;
    localparam int D_FOOD   = 5;
    localparam int D_BALL   = 6;
    localparam int D_BROOM  = 7;
    localparam int D_PILLS  = 8;
    localparam int D_AID    = 9;

    function automatic logic [2:0] pick_item(input logic [4:0] e);
        logic [2:0] it;
        it = IT_NONE;
        if (e[0])      it = IT_FOOD;
        else if (e[1]) it = IT_BALL;
        else if (e[2]) it = IT_BROOM;
        else if (e[3]) it = IT_PILLS;
        else if (e[4]) it = IT_AID;
        return it;
    endfunction

    // One-hot bubble {dying, sick, dirty, bored, hunger}, highest priority first.
    function automatic logic [4:0] pick_bubble(input logic hun, input logic bor,
                                               input logic dir, input logic sic,
                                               input logic dyi);
        logic [4:0] b;
        b = 5'b00000;
        if (dyi)      b = 5'b10000;
        else if (sic) b = 5'b01000;
        else if (hun) b = 5'b00001;
        else if (dir) b = 5'b00100;
        else if (bor) b = 5'b00010;
        return b;
    endfunction

    // Key path: bit 0 is start_key, bits 5:1 are care_key.
    logic [5:0] keys_raw;
    logic [5:0] keys_s;
    assign keys_raw = {care_key, start_key};

`ifdef PET_CTRL_KEY_SYNC_EN
    logic [5:0] sync1_q;
    logic [5:0] sync2_q;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= keys_raw;
            sync2_q <= sync1_q;
        end
    end
    assign keys_s = sync2_q;
`else
    assign keys_s = keys_raw;
`endif

    state_t      state_q, state_d;
    logic        armed_q;
    logic [5:0]  key_q;
    logic [5:0]  edge_q;
    logic [2:0]  pending_q, pending_d;
    logic [2:0]  item_q, item_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [4:0]  bubble_q, bubble_d;
    logic [14:0] draw_q, draw_d;
    logic [4:0]  given_q, given_d;

    logic [4:0] care_edge;
    logic       start_edge;
    logic       status_any;
    logic       anim_active;

    assign care_edge   = edge_q[5:1];
    assign start_edge  = edge_q[0];
    assign status_any  = hungry | bored | dirty | sick | dying;
    assign anim_active = (item_q != IT_NONE);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        item_d    = item_q;
        cnt_d     = cnt_q;
        bubble_d  = bubble_q;

        // A new care request is only latched when nothing is queued or playing.
        if ((pending_q == IT_NONE) && !anim_active && !asleep && (care_edge != 5'b0) &&
            (state_q != ST_END) && (state_q != ST_DEAD)) begin
            pending_d = pick_item(care_edge);
        end

        case (state_q)
            ST_RST:        if (armed_q) state_d = ST_START;
            ST_START:      if (draw_done) state_d = ST_WAIT_START;
            ST_WAIT_START: if (start_edge) state_d = ST_BG;
            ST_BG:         if (draw_done) state_d = ST_PET;
            ST_PET: begin
                if (draw_done) begin
                    if (anim_active) begin
                        state_d = ST_OBJ;
                    end else if (status_any) begin
                        state_d  = ST_STATUS;
                        bubble_d = pick_bubble(hungry, bored, dirty, sick, dying);
                    end else if (asleep) begin
                        state_d = ST_ZS;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_STATUS:     if (draw_done) state_d = asleep ? ST_ZS : ST_IDLE;
            ST_ZS:         if (draw_done) state_d = ST_IDLE;
            ST_OBJ:        if (draw_done) state_d = ST_IDLE;
            ST_IDLE: begin
                if (deceased) begin
                    state_d   = ST_END;
                    item_d    = IT_NONE;
                    pending_d = IT_NONE;
                    cnt_d     = 6'd0;
                end else if ((pending_q != IT_NONE) && !anim_active) begin
                    state_d   = ST_BG;
                    item_d    = pending_q;
                    pending_d = IT_NONE;
                    cnt_d     = 6'd0;
                end else if (frame_tick && anim_active && (cnt_q == ANIM_FRAMES - 6'd1)) begin
                    state_d = ST_GIVE;
                end else if (frame_tick) begin
                    state_d = ST_BG;
                    if (anim_active) cnt_d = cnt_q + 6'd1;
                end
            end
            ST_GIVE: begin
                state_d = ST_BG;
                item_d  = IT_NONE;
                cnt_d   = 6'd0;
            end
            ST_END:        if (draw_done) state_d = ST_DEAD;
            ST_DEAD:       state_d = ST_DEAD;
            default:       state_d = ST_RST;
        endcase
    end

    // Outputs are decoded from the next state so each request rises with its state.
    always_comb begin
        draw_d  = '0;
        given_d = '0;
        case (state_d)
            ST_BG:     draw_d[D_BG]    = 1'b1;
            ST_START:  draw_d[D_START] = 1'b1;
            ST_END:    draw_d[D_END]   = 1'b1;
            ST_PET:    draw_d[D_PET]   = 1'b1;
            ST_ZS:     draw_d[D_ZS]    = 1'b1;
            ST_STATUS: draw_d[14:10]   = bubble_d;
            ST_OBJ: begin
                case (item_d)
                    IT_FOOD:  draw_d[D_FOOD]  = 1'b1;
                    IT_BALL:  draw_d[D_BALL]  = 1'b1;
                    IT_BROOM: draw_d[D_BROOM] = 1'b1;
                    IT_PILLS: draw_d[D_PILLS] = 1'b1;
                    IT_AID:   draw_d[D_AID]   = 1'b1;
                    default:  draw_d          = '0;
                endcase
            end
            ST_GIVE: begin
                case (item_d)
                    IT_FOOD:  given_d[0] = 1'b1;
                    IT_BALL:  given_d[1] = 1'b1;
                    IT_BROOM: given_d[2] = 1'b1;
                    IT_PILLS: given_d[3] = 1'b1;
                    IT_AID:   given_d[4] = 1'b1;
                    default:  given_d    = '0;
                endcase
            end
            default: begin
                draw_d  = '0;
                given_d = '0;
            end
        endcase
    end

    // armed_q holds RST for one cycle after reset release.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_RST;
            armed_q   <= 1'b0;
            key_q     <= '0;
            edge_q    <= '0;
            pending_q <= IT_NONE;
            item_q    <= IT_NONE;
            cnt_q     <= 6'd0;
            bubble_q  <= 5'b0;
            draw_q    <= '0;
            given_q   <= '0;
        end else begin
            state_q   <= state_d;
            armed_q   <= 1'b1;
            key_q     <= keys_s;
            edge_q    <= keys_s & ~key_q;
            pending_q <= pending_d;
            item_q    <= item_d;
            cnt_q     <= cnt_d;
            bubble_q  <= bubble_d;
            draw_q    <= draw_d;
            given_q   <= given_d;
        end
    end

    assign draw_bg       = draw_q[D_BG];
    assign draw_start    = draw_q[D_START];
    assign draw_end      = draw_q[D_END];
    assign draw_pet      = draw_q[D_PET];
    assign draw_zs       = draw_q[D_ZS];
    assign draw_food     = draw_q[D_FOOD];
    assign draw_ball     = draw_q[D_BALL];
    assign draw_broom    = draw_q[D_BROOM];
    assign draw_pills    = draw_q[D_PILLS];
    assign draw_firstAid = draw_q[D_AID];
    assign draw_hunger   = draw_q[10];
    assign draw_bored    = draw_q[11];
    assign draw_dirty    = draw_q[12];
    assign draw_sick     = draw_q[13];
    assign draw_dying    = draw_q[14];
    assign foodGiven     = given_q[0];
    assign ballGiven     = given_q[1];
    assign broomGiven    = given_q[2];
    assign pillsGiven    = given_q[3];
    assign firstAidGiven = given_q[4];

endmodule

// File: doc/pet_controller.md
# pet_controller

Top-level sequencing FSM for the virtual-pet game. It consumes the pet status flags produced by the game datapath, along with the player's start and care buttons. It drives the one-hot sprite draw requests to the drawing engine and the one-cycle `*Given` care pulses back to the datapath. It sits between the board I/O, the datapath and the sprite draw engine.

## Interface
- `ANIM_FRAMES`, default 6'd30: number of frames an item animation lasts before its care pulse is issued (legal range 1–63).

- `clk` in 1: system clock.
- `resetn` in 1: reset, synchronous, active-low.
- `start_key` in 1: start button, active-high level.
- `care_key` in 5: care buttons, active-high levels. Bit 0 food, 1 ball, 2 broom, 3 pills, 4 first aid.
- `hungry`, `bored`, `dirty`, `sick`, `dying`, `deceased` in 1 each: datapath status flags.
- `asleep` in 1: pet is sleeping.
- `frame_tick` in 1: one-cycle pulse per display frame.
- `draw_done` in 1: draw engine has finished the requested sprite.
- `draw_bg`, `draw_start`, `draw_end`, `draw_pet`, `draw_zs`, `draw_food`, `draw_ball`, `draw_broom`, `draw_pills`, `draw_firstAid`, `draw_hunger`, `draw_bored`, `draw_dirty`, `draw_sick`, `draw_dying` out 1 each: draw requests; at most one is high at a time.
- `foodGiven`, `ballGiven`, `broomGiven`, `pillsGiven`, `firstAidGiven` out 1 each: one-cycle care pulses.

## Operation
- **Key edge detection:** `edge = key & ~key_q`.
- **Pending item register:** 3 bits, 0 means none.
  - Loaded by a `care_key` edge only when empty, not asleep, and no animation is active.
  - If several bits rise in the same cycle, priority is food > ball > broom > pills > first aid.
  - Further edges are ignored until the pending item is consumed.
- **States:**
  - `RST`: entered on reset; goes to `START` on the next edge.
  - `START`: `draw_start` high until `draw_done`, then `WAIT_START`.
  - `WAIT_START`: a `start_key` edge goes to `BG`.
  - `BG`: `draw_bg` high until `draw_done`, then `PET`.
  - `PET`: `draw_pet` high until `draw_done`. Exit priority:
    - animation active → `OBJ`;
    - otherwise any status flag → `STATUS`;
    - otherwise `asleep` → `ZS`;
    - otherwise `IDLE`.
  - `STATUS`: draws one bubble, priority dying > sick > hungry > dirty > bored. On `draw_done`, goes to `ZS` if `asleep`, else `IDLE`.
  - `ZS`: `draw_zs` high until `draw_done`, then `IDLE`.
  - `OBJ`: draws the item sprite matching the active item, until `draw_done`, then `IDLE`.
  - `IDLE`: exit priority:
    1. `deceased` → `END`; any animation is aborted and pending is cleared, with no care pulse.
    2. Pending item non-empty and no animation → start the animation: item latched, `anim_cnt` = 0, pending cleared, go to `BG`.
    3. `frame_tick` with animation active and `anim_cnt == ANIM_FRAMES-1` → `GIVE`.
    4. `frame_tick` otherwise → increment `anim_cnt` if animating, go to `BG`.
  - `GIVE`: the matching `*Given` is high for exactly this cycle; animation cleared; go to `BG`.
  - `END`: `draw_end` high until `draw_done`, then `DEAD`.
  - `DEAD`: all outputs 0; left only by reset.
- **`draw_done` rules:**
  - Honoured only while a draw request is high, including the first cycle of that request.
  - Ignored in all other states.
- **Status flag sampling:** status flags are sampled at the `PET`/`STATUS` exit cycle only.
- **Counter width:** `anim_cnt` is 6 bits and never wraps (bounded by `ANIM_FRAMES-1`).

## Timing
- **Reset:**
  - Every output is 0 while `resetn` is sampled low.
  - `draw_start` rises on the second edge after `resetn` is sampled high (`RST` → `START`).
- **Registered outputs:** all outputs are registered. A request goes high on the same edge the state is entered and falls on the edge after `draw_done` is sampled high.
- **Back-to-back draws:** no idle cycle between consecutive draw states.
- **Key latency:** a key rising on cycle N is edge-detected on N+1 and can be acted on in `IDLE` on N+2.
- **Animation length:** the care pulse follows the start of the animation after exactly `ANIM_FRAMES` `frame_tick` pulses received in `IDLE`. Ticks arriving outside `IDLE` are dropped.
- **Simultaneous `deceased` and `frame_tick` in `IDLE`:** `deceased` wins.
- **Reset mid-operation:** immediate return to `RST`; pending, animation and counters are cleared; no pulse is emitted.

## Configuration
- **`PET_CTRL_KEY_SYNC_EN`**
  - Defined: `start_key` and `care_key` each pass through a two-flop synchronizer before edge detection. This adds 2 cycles to key latency, so a key can be acted on at N+4.
  - Undefined: keys feed edge detection directly, giving the N+2 latency above.

## Test plan
- **Reset and start:** reset, model returns `draw_done` 3 cycles after each request.
  - `draw_start` rises on edge 2, then the FSM waits.
  - `start_key` pulse → `draw_bg`, then `draw_pet`, then `IDLE`.
- **Status bubble:** `hungry`=1 and `dirty`=1 at `PET` exit → only `draw_hunger` is requested, then `IDLE`.
  - `asleep`=1 → `draw_zs` follows the bubble.
- **Food animation:** `care_key`=5'b00001 in `IDLE`, `ANIM_FRAMES`=3.
  - Each frame draws bg, pet, food.
  - After the 3rd tick, `foodGiven` is high for exactly 1 cycle.
- **Simultaneous and blocked keys:**
  - `care_key`=5'b10010 rising together → ball is selected.
  - Keys pressed during an animation or while `asleep` produce no later pulse.
- **Death during animation:** `deceased`=1 with `frame_tick` in `IDLE` mid-animation.
  - `draw_end` is requested, no `*Given` pulse, then `DEAD` holds all outputs at 0.
- **Mid-draw reset:** `resetn` low while `draw_bg` is high → all outputs 0 next edge; restart shows `draw_start`.
